// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/ERET sequencer.
package exc_ctrl_pkg;

  // CP0 ExcCode values produced by this block
  typedef enum logic [5:0] {
    EXC_INT  = 6'd0,
    EXC_ADEL = 6'd4,
    EXC_ADES = 6'd5,
    EXC_SYS  = 6'd8,
    EXC_BP   = 6'd9,
    EXC_RI   = 6'd10,
    EXC_OV   = 6'd12
  } exc_code_t;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } exc_state_t;

  // Bit positions inside m_exc_flags
  localparam int unsigned FLAG_W          = 7;
  localparam int unsigned FLAG_ADEL_FETCH = 6;
  localparam int unsigned FLAG_RI         = 5;
  localparam int unsigned FLAG_OV         = 4;
  localparam int unsigned FLAG_SYS        = 3;
  localparam int unsigned FLAG_BP         = 2;
  localparam int unsigned FLAG_ADEL_DATA  = 1;
  localparam int unsigned FLAG_ADES_DATA  = 0;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Ranks the M-stage exception flags, the CP0 interrupt and ERET into one
// CP0 request; purely combinational.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [6:0] flags_i,
  input  logic       interrupt_i,
  input  logic       eret_i,
  output logic       hit_o,
  output logic [5:0] code_o,
  output logic       is_bad_addr_o,
  output logic       use_data_addr_o,
  output logic       is_eret_o
);

  exc_code_t code_e;
  logic      any_exc;

  assign any_exc = interrupt_i | (|flags_i);

  // Highest-priority source wins; address faults also flag BadVAddr
  always_comb begin
    code_e          = EXC_INT;
    is_bad_addr_o   = 1'b0;
    use_data_addr_o = 1'b0;
    if (interrupt_i) begin
      code_e = EXC_INT;
    end else if (flags_i[FLAG_ADEL_FETCH]) begin
      code_e        = EXC_ADEL;
      is_bad_addr_o = 1'b1;
    end else if (flags_i[FLAG_RI]) begin
      code_e = EXC_RI;
    end else if (flags_i[FLAG_OV]) begin
      code_e = EXC_OV;
    end else if (flags_i[FLAG_SYS]) begin
      code_e = EXC_SYS;
    end else if (flags_i[FLAG_BP]) begin
      code_e = EXC_BP;
    end else if (flags_i[FLAG_ADEL_DATA]) begin
      code_e          = EXC_ADEL;
      is_bad_addr_o   = 1'b1;
      use_data_addr_o = 1'b1;
    end else if (flags_i[FLAG_ADES_DATA]) begin
      code_e          = EXC_ADES;
      is_bad_addr_o   = 1'b1;
      use_data_addr_o = 1'b1;
    end
  end

  assign code_o    = code_e;
  assign hit_o     = any_exc | eret_i;
  // ERET only survives when no exception or interrupt competes with it
  assign is_eret_o = eret_i & ~any_exc;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: captures the committing M-stage event, strobes
// CP0 for one cycle, flushes the front end and redirects fetch.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_in_delay,
  input  logic [6:0]  m_exc_flags,
  input  logic [31:0] m_data_addr,
  input  logic        m_eret,
  input  logic        cp0_interrupt,
  input  logic [31:0] cp0_epc,
  input  logic        redirect_ready,
  output logic        m_kill,
  output logic        exception,
  output logic [5:0]  exc_code,
  output logic        is_bad_addr,
  output logic [31:0] bad_addr,
  output logic [31:0] exc_pc,
  output logic        in_delay_slot,
  output logic        eret,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  exc_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              exception_q;
  logic              eret_q;
  logic [5:0]        exc_code_q;
  logic              is_bad_addr_q;
  logic [31:0]       bad_addr_q;
  logic [31:0]       exc_pc_q;
  logic              in_delay_slot_q;
  logic              flush_q;
  logic              busy_q;
  logic              redirect_valid_q;
  logic [31:0]       redirect_pc_q;

  logic              enc_hit;
  logic [5:0]        enc_code;
  logic              enc_is_bad_addr;
  logic              enc_use_data_addr;
  logic              enc_is_eret;
  logic              take;
  logic [31:0]       bad_addr_d;
  logic [31:0]       redirect_pc_d;

  exc_prio_enc u_prio_enc (
    .flags_i         (m_exc_flags),
    .interrupt_i     (cp0_interrupt),
    .eret_i          (m_eret),
    .hit_o           (enc_hit),
    .code_o          (enc_code),
    .is_bad_addr_o   (enc_is_bad_addr),
    .use_data_addr_o (enc_use_data_addr),
    .is_eret_o       (enc_is_eret)
  );

  assign take   = (state_q == IDLE) & m_valid & enc_hit;
  assign m_kill = take;

  // Faulting address: fetch faults report the PC, data faults the EA
  always_comb begin
    bad_addr_d = 32'h0;
    if (enc_is_bad_addr) begin
      bad_addr_d = enc_use_data_addr ? m_data_addr : m_pc;
    end
  end

  // ERET returns to EPC as seen at take time; everything else to the vector
  assign redirect_pc_d = enc_is_eret ? cp0_epc : EXC_VECTOR;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      exception_q      <= 1'b0;
      eret_q           <= 1'b0;
      exc_code_q       <= 6'h0;
      is_bad_addr_q    <= 1'b0;
      bad_addr_q       <= 32'h0;
      exc_pc_q         <= 32'h0;
      in_delay_slot_q  <= 1'b0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q         <= COMMIT;
            exception_q     <= ~enc_is_eret;
            eret_q          <= enc_is_eret;
            exc_code_q      <= enc_code;
            is_bad_addr_q   <= enc_is_bad_addr;
            bad_addr_q      <= bad_addr_d;
            exc_pc_q        <= m_pc;
            in_delay_slot_q <= m_in_delay;
            redirect_pc_q   <= redirect_pc_d;
            flush_q         <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        COMMIT: begin
          exception_q <= 1'b0;
          eret_q      <= 1'b0;
          cnt_q       <= CNT_W'(FLUSH_CYCLES - 1);
          if (FLUSH_CYCLES == 1) begin
            state_q          <= REDIRECT;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b1;
          end else begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q          <= REDIRECT;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign exception      = exception_q;
  assign eret           = eret_q;
  assign exc_code       = exc_code_q;
  assign is_bad_addr    = is_bad_addr_q;
  assign bad_addr       = bad_addr_q;
  assign exc_pc         = exc_pc_q;
  assign in_delay_slot  = in_delay_slot_q;
  assign flush          = flush_q;
  assign stall          = busy_q;
  assign busy           = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed table, corner sequences and
// random stimulus against a cycles-since-take reference model.
module tb_exc_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_in_delay;
  logic [6:0]  m_exc_flags;
  logic [31:0] m_data_addr;
  logic        m_eret;
  logic        cp0_interrupt;
  logic [31:0] cp0_epc;
  logic        redirect_ready;
  logic        m_kill;
  logic        exception;
  logic [5:0]  exc_code;
  logic        is_bad_addr;
  logic [31:0] bad_addr;
  logic [31:0] exc_pc;
  logic        in_delay_slot;
  logic        eret;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc),
    .m_in_delay(m_in_delay), .m_exc_flags(m_exc_flags),
    .m_data_addr(m_data_addr), .m_eret(m_eret),
    .cp0_interrupt(cp0_interrupt), .cp0_epc(cp0_epc),
    .redirect_ready(redirect_ready), .m_kill(m_kill),
    .exception(exception), .exc_code(exc_code), .is_bad_addr(is_bad_addr),
    .bad_addr(bad_addr), .exc_pc(exc_pc), .in_delay_slot(in_delay_slot),
    .eret(eret), .flush(flush), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // p = cycles since the take edge (0 = idle); outputs follow from p.
  int          p = 0;
  logic [5:0]  r_code;
  logic        r_is_eret;
  logic        r_bad;
  logic [31:0] r_badaddr;
  logic [31:0] r_pc;
  logic        r_dly;
  logic [31:0] r_rpc;

  // Flag bits in priority order and their ExcCodes
  int pri_bit  [7] = '{6, 5, 4, 3, 2, 1, 0};
  int pri_code [7] = '{4, 10, 12, 8, 9, 4, 5};

  function automatic logic model_take();
    return (p == 0) && m_valid && (cp0_interrupt || (m_exc_flags != 7'd0) || m_eret);
  endfunction

  task automatic model_capture();
    bit found;
    found     = 1'b0;
    r_is_eret = 1'b0;
    r_bad     = 1'b0;
    r_badaddr = 32'h0;
    r_code    = 6'd0;
    if (!cp0_interrupt) begin
      for (int i = 0; i < 7; i++) begin
        if (!found && m_exc_flags[pri_bit[i]]) begin
          found  = 1'b1;
          r_code = 6'(pri_code[i]);
          if (pri_bit[i] == 6) begin
            r_bad = 1'b1; r_badaddr = m_pc;
          end else if (pri_bit[i] <= 1) begin
            r_bad = 1'b1; r_badaddr = m_data_addr;
          end
        end
      end
      if (!found) r_is_eret = 1'b1;
    end
    r_pc  = m_pc;
    r_dly = m_in_delay;
    r_rpc = r_is_eret ? cp0_epc : VEC;
  endtask

  task automatic model_step();
    if (p == 0) begin
      if (model_take()) begin
        model_capture();
        p = 1;
      end
    end else if (p >= FC + 1) begin
      if (redirect_ready) p = 0;
    end else begin
      p++;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".exception"}, 32'(exception), 32'((p == 1) && !r_is_eret));
    chk({tag, ".eret"}, 32'(eret), 32'((p == 1) && r_is_eret));
    chk({tag, ".flush"}, 32'(flush), 32'((p >= 1) && (p <= FC)));
    chk({tag, ".stall"}, 32'(stall), 32'(p != 0));
    chk({tag, ".busy"}, 32'(busy), 32'(p != 0));
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(p >= FC + 1));
    if (p == 1) begin
      chk({tag, ".exc_code"}, 32'(exc_code), 32'(r_code));
      chk({tag, ".is_bad_addr"}, 32'(is_bad_addr), 32'(r_bad));
      chk({tag, ".bad_addr"}, bad_addr, r_badaddr);
      chk({tag, ".exc_pc"}, exc_pc, r_pc);
      chk({tag, ".in_delay_slot"}, 32'(in_delay_slot), 32'(r_dly));
    end
    if (p >= FC + 1) chk({tag, ".redirect_pc"}, redirect_pc, r_rpc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".exception"}, 32'(exception), 32'h0);
    chk({tag, ".eret"}, 32'(eret), 32'h0);
    chk({tag, ".exc_code"}, 32'(exc_code), 32'h0);
    chk({tag, ".is_bad_addr"}, 32'(is_bad_addr), 32'h0);
    chk({tag, ".bad_addr"}, bad_addr, 32'h0);
    chk({tag, ".exc_pc"}, exc_pc, 32'h0);
    chk({tag, ".in_delay_slot"}, 32'(in_delay_slot), 32'h0);
    chk({tag, ".flush"}, 32'(flush), 32'h0);
    chk({tag, ".stall"}, 32'(stall), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'h0);
    chk({tag, ".redirect_pc"}, redirect_pc, 32'h0);
  endtask

  // One clock: check m_kill before the edge, step model, check after it
  task automatic cycle(input string tag);
    #1;
    chk({tag, ".m_kill"}, 32'(m_kill), 32'(model_take()));
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    m_valid        = 1'b0;
    m_pc           = 32'h0;
    m_in_delay     = 1'b0;
    m_exc_flags    = 7'd0;
    m_data_addr    = 32'h0;
    m_eret         = 1'b0;
    cp0_interrupt  = 1'b0;
    cp0_epc        = 32'h0;
    redirect_ready = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [6:0]  flags;
    logic        intr;
    logic        v_eret;
    logic [31:0] pc;
    logic [31:0] daddr;
    logic        dly;
    logic [31:0] epc;
    logic [5:0]  code;
    logic        e_exc;
    logic        e_eret;
    logic        e_bad;
    logic [31:0] e_baddr;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vt [12];

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{7'b0010000, 1'b0, 1'b0, 32'hBFC0_0100, 32'h0, 1'b0, 32'h0, 6'd12, 1'b1, 1'b0, 1'b0, 32'h0, VEC};
    vt[1]  = '{7'b0000001, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0003, 1'b1, 32'h0, 6'd5, 1'b1, 1'b0, 1'b1, 32'h8000_0003, VEC};
    vt[2]  = '{7'b0100000, 1'b1, 1'b0, 32'h8000_2000, 32'h0, 1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 32'h0, VEC};
    vt[3]  = '{7'b0000000, 1'b0, 1'b1, 32'h8000_3000, 32'h0, 1'b0, 32'hBFC0_0200, 6'd0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hBFC0_0200};
    vt[4]  = '{7'b1000000, 1'b0, 1'b0, 32'h0000_1002, 32'h5555_0000, 1'b0, 32'h0, 6'd4, 1'b1, 1'b0, 1'b1, 32'h0000_1002, VEC};
    vt[5]  = '{7'b0000010, 1'b0, 1'b0, 32'h8000_4000, 32'h0000_1235, 1'b0, 32'h0, 6'd4, 1'b1, 1'b0, 1'b1, 32'h0000_1235, VEC};
    vt[6]  = '{7'b0001100, 1'b0, 1'b0, 32'h8000_5000, 32'h0, 1'b1, 32'h0, 6'd8, 1'b1, 1'b0, 1'b0, 32'h0, VEC};
    vt[7]  = '{7'b0000100, 1'b0, 1'b1, 32'h8000_6000, 32'h0, 1'b0, 32'h1234_5678, 6'd9, 1'b1, 1'b0, 1'b0, 32'h0, VEC};
    vt[8]  = '{7'b1111111, 1'b0, 1'b0, 32'h8000_7000, 32'h9999_0000, 1'b0, 32'h0, 6'd4, 1'b1, 1'b0, 1'b1, 32'h8000_7000, VEC};
    vt[9]  = '{7'b0000011, 1'b0, 1'b0, 32'h8000_8000, 32'h0000_0F01, 1'b0, 32'h0, 6'd4, 1'b1, 1'b0, 1'b1, 32'h0000_0F01, VEC};
    vt[10] = '{7'b0000000, 1'b1, 1'b1, 32'h8000_9000, 32'h0, 1'b1, 32'hDEAD_0000, 6'd0, 1'b1, 1'b0, 1'b0, 32'h0, VEC};
    vt[11] = '{7'b0110000, 1'b0, 1'b0, 32'h8000_A000, 32'h0, 1'b0, 32'h0, 6'd10, 1'b1, 1'b0, 1'b0, 32'h0, VEC};

    // Reset state
    idle_inputs();
    reset = 1'b1;
    #1;
    check_zero("reset");
    chk("reset.m_kill", 32'(m_kill), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("idle");

    // Directed table
    for (int i = 0; i < 12; i++) begin
      m_valid       = 1'b1;
      m_exc_flags   = vt[i].flags;
      cp0_interrupt = vt[i].intr;
      m_eret        = vt[i].v_eret;
      m_pc          = vt[i].pc;
      m_data_addr   = vt[i].daddr;
      m_in_delay    = vt[i].dly;
      cp0_epc       = vt[i].epc;
      cycle("tbl_take");
      chk($sformatf("tbl%0d.exception", i), 32'(exception), 32'(vt[i].e_exc));
      chk($sformatf("tbl%0d.eret", i), 32'(eret), 32'(vt[i].e_eret));
      if (vt[i].e_exc) chk($sformatf("tbl%0d.exc_code", i), 32'(exc_code), 32'(vt[i].code));
      chk($sformatf("tbl%0d.is_bad_addr", i), 32'(is_bad_addr), 32'(vt[i].e_bad));
      chk($sformatf("tbl%0d.bad_addr", i), bad_addr, vt[i].e_baddr);
      chk($sformatf("tbl%0d.exc_pc", i), exc_pc, vt[i].pc);
      chk($sformatf("tbl%0d.in_delay_slot", i), 32'(in_delay_slot), 32'(vt[i].dly));
      chk($sformatf("tbl%0d.flush", i), 32'(flush), 32'h1);
      idle_inputs();
      for (int k = 0; k < FC; k++) cycle("tbl_seq");
      chk($sformatf("tbl%0d.redirect_valid", i), 32'(redirect_valid), 32'h1);
      chk($sformatf("tbl%0d.redirect_pc", i), redirect_pc, vt[i].e_rpc);
      cycle("tbl_hs");
      chk($sformatf("tbl%0d.busy_after", i), 32'(busy), 32'h0);
    end

    // m_valid low: flags must not be taken
    m_valid = 1'b0; m_exc_flags = 7'b0010000; cp0_interrupt = 1'b1; m_eret = 1'b1;
    cycle("novalid");
    idle_inputs();

    // Redirect held off for 5 cycles; a new Sys request meanwhile is ignored
    m_valid = 1'b1; m_exc_flags = 7'b0000100; m_pc = 32'h8000_B000; redirect_ready = 1'b0;
    cycle("hold_take");
    m_valid = 1'b0; m_exc_flags = 7'd0;
    for (int k = 0; k < FC; k++) cycle("hold_seq");
    m_valid = 1'b1; m_exc_flags = 7'b0001000; m_pc = 32'h8000_C000; cp0_epc = 32'h1111_2222;
    for (int k = 0; k < 5; k++) begin
      cycle("hold_wait");
      chk("hold.redirect_valid", 32'(redirect_valid), 32'h1);
      chk("hold.redirect_pc", redirect_pc, VEC);
      chk("hold.exception", 32'(exception), 32'h0);
    end
    idle_inputs();
    cycle("hold_hs");
    chk("hold.idle", 32'(busy), 32'h0);
    // Earliest next take is the cycle right after the handshake
    m_valid = 1'b1; m_exc_flags = 7'b0010000; m_pc = 32'h8000_D000;
    cycle("back2back");
    chk("back2back.exception", 32'(exception), 32'h1);
    idle_inputs();
    for (int k = 0; k < FC + 1; k++) cycle("back2back_seq");

    // Reset asserted in FLUSH clears outputs without a clock edge
    m_valid = 1'b1; m_exc_flags = 7'b0000001; m_data_addr = 32'h8000_0007; m_pc = 32'h8000_E000;
    cycle("rst_take");
    idle_inputs();
    cycle("rst_flush");
    chk("rst.in_flush", 32'(flush), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    p = 0;
    r_is_eret = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst_release");
    cycle("rst_idle");

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      m_valid        = 1'($urandom_range(0, 3) != 0);
      m_exc_flags    = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      cp0_interrupt  = 1'($urandom_range(0, 7) == 0);
      m_eret         = 1'($urandom_range(0, 5) == 0);
      m_pc           = $urandom;
      m_data_addr    = $urandom;
      m_in_delay     = 1'($urandom);
      cp0_epc        = $urandom;
      redirect_ready = 1'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
